// File: rtl/concat_n.sv
// Merges CHANNELS upstream request/ack lists into a single downstream list,
// either one list after another (MODE=0) or round-robin interleaved (MODE=1).
module concat_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic [CHANNELS-1:0]       in_req,
  input  logic [CHANNELS-1:0]       in_ack,
  input  logic [CHANNELS-1:0]       in_eol,
  input  logic [CHANNELS*WIDTH-1:0] in_value,
  input  logic                      req,
  output logic                      ack,
  output logic                      eol,
  output logic [WIDTH-1:0]          value
);

  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [CHANNELS-1:0] exhausted_reg, exhausted_next;
  logic                req_on_reg, req_on_next;
  logic                ack_reg, ack_next;
  logic [WIDTH-1:0]    value_reg, value_next;
  logic                req_prev_reg;

  logic [WIDTH-1:0]    lane_value [CHANNELS];
  logic [CHANNELS-1:0] exhausted_probe;
  logic                req_edge;
  logic                sel_ack;
  logic                sel_eol;

  // Next channel after 'from' (wrapping) whose mask bit is clear; 'from'
  // itself is the last candidate so a lone live channel keeps being served.
  function automatic logic [SEL_W-1:0] next_free(input logic [SEL_W-1:0]    from,
                                                 input logic [CHANNELS-1:0] mask);
    int idx;
    next_free = from;
    for (int i = CHANNELS; i >= 1; i--) begin
      idx = (int'(from) + i) % CHANNELS;
      if (!mask[idx]) begin
        next_free = SEL_W'(idx);
      end
    end
  endfunction

  // Only the selected channel ever sees a request, so in_req is one-hot or zero.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      assign lane_value[gi] = in_value[gi*WIDTH +: WIDTH];
      assign in_req[gi]     = req_on_reg && (sel_reg == SEL_W'(gi));
    end
  endgenerate

  assign req_edge        = req && !req_prev_reg;
  assign sel_ack         = in_ack[sel_reg];
  assign sel_eol         = in_eol[sel_reg];
  assign exhausted_probe = exhausted_reg | (CHANNELS'(1) << sel_reg);

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    exhausted_next = exhausted_reg;
    req_on_next    = req_on_reg;
    ack_next       = 1'b0;
    value_next     = value_reg;

    case (state_reg)
      IDLE: begin
        if (req_edge) begin
          state_next = PROBE;
        end
      end

      PROBE: begin
        if (!sel_eol) begin
          state_next  = WAIT;
          req_on_next = 1'b1;
        end else begin
          exhausted_next = exhausted_probe;
          if (&exhausted_probe) begin
            state_next = DONE;
          end else begin
            sel_next = next_free(sel_reg, exhausted_probe);
          end
        end
      end

      WAIT: begin
        // An ack that arrives together with eol still carries a valid element.
        if (sel_ack) begin
          value_next  = lane_value[sel_reg];
          ack_next    = 1'b1;
          req_on_next = 1'b0;
          state_next  = IDLE;
          if (MODE == 1) begin
            sel_next = next_free(sel_reg, exhausted_reg);
          end
        end
      end

      DONE: begin
        state_next = DONE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      exhausted_reg <= '0;
      req_on_reg    <= 1'b0;
      ack_reg       <= 1'b0;
      value_reg     <= '0;
      // Starting high means a req already asserted at reset release is not an edge.
      req_prev_reg  <= 1'b1;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      exhausted_reg <= exhausted_next;
      req_on_reg    <= req_on_next;
      ack_reg       <= ack_next;
      value_reg     <= value_next;
      req_prev_reg  <= req;
    end
  end

  assign ack   = ack_reg;
  assign eol   = (state_reg == DONE);
  assign value = value_reg;

endmodule

// File: doc/concat_n.md
CONCAT_N -- requirements
Module: concat_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of every list element.
REQ-002 SHALL have parameter CHANNELS, default 4: number of upstream lists; legal range 2..16.
REQ-003 SHALL have parameter MODE, default 0: 0 = sequential concatenation, 1 = round-robin interleave.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_req, output, CHANNELS bits: per-channel element request to upstream list.
REQ-007 SHALL have port in_ack, input, CHANNELS bits: per-channel upstream element-valid pulse.
REQ-008 SHALL have port in_eol, input, CHANNELS bits: per-channel upstream list-exhausted flag.
REQ-009 SHALL have port in_value, input, CHANNELS*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port req, input, 1 bit: downstream request; a rising edge requests one element.
REQ-011 SHALL have port ack, output, 1 bit: one-cycle pulse; value is valid while ack is high.
REQ-012 SHALL have port eol, output, 1 bit: merged list exhausted.
REQ-013 SHALL have port value, output, WIDTH bits: current element, registered.

Function
REQ-014 SHALL detect a request as req=1 sampled while the registered previous req=0; the detection SHALL be acted on only in state IDLE, and edges arriving in any other state SHALL be ignored.
REQ-015 SHALL implement states IDLE, PROBE, WAIT and DONE, plus a registered channel index sel and a CHANNELS-bit exhausted mask.
REQ-016 IDLE: on a detected edge, the next state SHALL be PROBE; otherwise the block SHALL remain in IDLE.
REQ-017 PROBE with in_eol[sel]=0: the block SHALL go to WAIT and assert in_req[sel] from the next cycle.
REQ-018 PROBE with in_eol[sel]=1: the block SHALL set exhausted[sel] and move sel to the next index, modulo CHANNELS, whose exhausted bit is clear (one cycle per skip) and remain in PROBE; if all bits are then set, it SHALL go to DONE.
REQ-019 WAIT: in_req[sel] SHALL be held high until in_ack[sel] is sampled at 1; on that edge the block SHALL latch in_value[sel] into value, pulse ack for exactly one cycle, clear in_req[sel], and return to IDLE.
REQ-020 MODE=1 SHALL advance sel after every accepted element to the next index, modulo CHANNELS, whose exhausted bit is clear; MODE=0 SHALL advance sel only per REQ-018.
REQ-021 In WAIT, in_ack on an unselected channel SHALL be ignored; in_ack[sel] and in_eol[sel] both high SHALL be treated as an accepted element.
REQ-022 DONE: eol SHALL be 1 and ack 0; all further requests SHALL be ignored until reset.
REQ-023 At most one in_req bit SHALL be high at any time; in_req SHALL be low for at least one cycle between consecutive requests to the same channel.
REQ-024 Latency: with an upstream acking one cycle after in_req, ack SHALL be high 4 cycles after the edge at which req is first sampled high, plus one cycle per skipped exhausted channel.
REQ-025 value SHALL hold the last accepted element between acks.

Reset
REQ-026 With reset high, on the next edge the block SHALL enter IDLE, set sel=0, clear exhausted, and drive in_req=0, ack=0, eol=0, value=0.
REQ-027 The registered previous-req SHALL reset to 1, so that a req held high across reset release is not a request.
REQ-028 Reset mid-transaction SHALL abandon the transaction with no ack pulse.

Verification
REQ-029 MODE=0, CHANNELS=3, lists [1,2],[],[7]: four req edges -> acks with 1, 2, 7; the fourth edge -> eol=1 and no ack.
REQ-030 MODE=1, CHANNELS=3, lists [1,2,3],[10],[20,21]: seven edges -> 1, 10, 20, 2, 21, 3, then eol=1.
REQ-031 All four channels empty: first edge -> eol=1 within 6 cycles; ack never asserts; in_req stays 0.
REQ-032 Reset asserted while in WAIT with upstreams also reset: in_req=0 and ack=0 on the next cycle; the next request returns the first element of channel 0.
REQ-033 req held high through reset release -> no in_req activity until req falls and rises again.
REQ-034 WIDTH=16, channel 2 element 0xBEEF, channels 0-1 empty -> value=0xBEEF with a single ack pulse.
